stack_op_sequencer: RTL
=======================

Name: stack_op_sequencer

Overview:
- Command-side initiator for the 64-entry register stack: accepts high-level stack commands over a valid/ready handshake and drives the stack's stackOP/w inputs.
- Reads the stack's a/b (top/next) outputs to compute arithmetic results, tracks stack depth, rejects underflowing commands and flags overflow.
- Sits between the processor decode stage and register_stack.

Parameters:
DEPTH, 64, stack capacity in entries; must match register_stack.
WIDTH, 16, data width of w, a, b, cmd_imm, rsp_top.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST_N  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command this cycle.
cmd_op  input  4  opcode: 0 NOP, 1 PUSH, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 POP, 7 POP2, 8 SWAP, 9 DUP; 10-15 illegal.
cmd_imm  input  WIDTH  immediate for PUSH.
stackOP  output  3  to register_stack: 0 hold, 1 push w, 2 replace top two with w, 3 pop, 4 pop two, 5 swap.
w  output  WIDTH  write data to register_stack.
a  input  WIDTH  stack top (signed).
b  input  WIDTH  stack next (signed).
rsp_valid  output  1  one-cycle pulse: command completed.
rsp_err  output  1  qualifies rsp_valid: command rejected, stack untouched.
rsp_top  output  WIDTH  value of a sampled after completion.
depth  output  7  current entry count, 0..DEPTH.
overflow  output  1  sticky: a push occurred at depth DEPTH.

Behaviour:
- Reset (async, RST_N low): state IDLE, stackOP=0, w=0, rsp_valid=0, rsp_err=0, rsp_top=0, depth=0, overflow=0, cmd_ready=0 during reset. Mid-operation reset aborts the in-flight command with no response.
- FSM states IDLE, ISSUE, SETTLE, RESP. cmd_ready=1 only in IDLE.
- IDLE: on cmd_valid, register op/imm and evaluate legality against current depth.
  - Illegal opcode, or underflow: go to RESP with rsp_err=1. Underflow means depth<2 for ADD/SUB/AND/OR/POP2/SWAP, or depth<1 for POP/DUP.
  - NOP: go to RESP with rsp_err=0 and stackOP held 0.
  - Otherwise: register stackOP/w and go to ISSUE.
  - w values: PUSH w=cmd_imm (op 1); ADD w=b+a; SUB w=b-a; AND w=b&a; OR w=b|a (all op 2, mod 2^WIDTH wrap, no saturation); DUP w=a (op 1); POP op 3; POP2 op 4; SWAP op 5 (w=0 for these three).
- ISSUE: stackOP/w held for exactly one cycle. register_stack captures at the ISSUE->SETTLE edge. Depth updates on the same edge: +1 for PUSH/DUP saturating at DEPTH, -1 for ADD/SUB/AND/OR/POP, -2 for POP2, 0 for SWAP. Push at depth DEPTH sets overflow; depth stays DEPTH and the bottom entry is lost by the stack.
- SETTLE: stackOP=0, w=0. rsp_top<=a on exit.
- RESP: rsp_valid=1 for one cycle, rsp_err valid. Return to IDLE. rsp_valid/rsp_err are 0 in all other states.
- Latency, accept edge to rsp_valid: legal command 3 cycles; error or NOP 1 cycle. Throughput: one command per 4 cycles (legal) or per 2 cycles (error/NOP).
- stackOP is never nonzero outside ISSUE, and never nonzero for a rejected command.
- overflow clears only on reset.
- cmd_valid in non-IDLE states is ignored (not accepted).

Test Plan:
- Reset, PUSH 1 -> stackOP=1,w=1 for one cycle; rsp_valid with rsp_err=0, rsp_top=1, depth=1.
- PUSH 1, PUSH 4, ADD -> w=5 with stackOP=2; rsp_top=5, depth=2. Then SUB with a=5 (stack 0,5 after PUSH 0 first) -> checks b-a wrap: PUSH 0, PUSH 5, SUB gives rsp_top=0xFFFB.
- Empty stack, POP -> rsp_err=1 within 1 cycle, stackOP stays 0, depth=0. Depth 1, SWAP -> rsp_err=1.
- PUSH 1, PUSH 2, SWAP -> rsp_top=1; DUP -> rsp_top=1, depth=3; POP2 -> rsp_top=2, depth=1.
- 65 PUSHes of 1..65 -> depth saturates at 64, overflow=1 after the 65th; 63 POPs -> rsp_top=2, depth=1 (entry 1 lost); POP -> depth=0; overflow stays 1 until RST_N pulsed.
- Assert RST_N low during ISSUE of a PUSH -> all outputs at reset values asynchronously; no rsp_valid after release; cmd_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: turns high-level stack commands into register_stack stackOP/w strobes and reports results.
// Latency: accept edge to rsp_valid is 3 cycles for executed commands, 1 cycle for NOP or rejected commands.
// Backpressure: cmd_ready only in IDLE, so one command per 4 cycles (executed) or per 2 cycles (NOP/rejected).
module stack_op_sequencer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [2:0]       stackOP,
  output logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_top,
  output logic [6:0]       depth,
  output logic             overflow
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_POP  = 4'd6;
  localparam logic [3:0] OP_POP2 = 4'd7;
  localparam logic [3:0] OP_SWAP = 4'd8;
  localparam logic [3:0] OP_DUP  = 4'd9;

  localparam logic [2:0] SOP_HOLD = 3'd0;
  localparam logic [2:0] SOP_PUSH = 3'd1;
  localparam logic [2:0] SOP_REPL = 3'd2;
  localparam logic [2:0] SOP_POP  = 3'd3;
  localparam logic [2:0] SOP_POP2 = 3'd4;
  localparam logic [2:0] SOP_SWAP = 3'd5;

  localparam logic [6:0] DEPTH_C = 7'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [2:0]       sop_q, sop_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic [6:0]       depth_q, depth_d;

  logic             illegal, underflow;
  logic [2:0]       cmd_sop;
  logic [WIDTH-1:0] cmd_w;

  // Decode the offered command: legality against current depth and the stack strobe it maps to.
  always_comb begin
    illegal   = 1'b0;
    underflow = 1'b0;
    cmd_sop   = SOP_HOLD;
    cmd_w     = '0;
    case (cmd_op)
      OP_NOP:  cmd_sop = SOP_HOLD;
      OP_PUSH: begin cmd_sop = SOP_PUSH; cmd_w = cmd_imm; end
      OP_ADD:  begin underflow = (depth_q < 7'd2); cmd_sop = SOP_REPL; cmd_w = b + a; end
      OP_SUB:  begin underflow = (depth_q < 7'd2); cmd_sop = SOP_REPL; cmd_w = b - a; end
      OP_AND:  begin underflow = (depth_q < 7'd2); cmd_sop = SOP_REPL; cmd_w = b & a; end
      OP_OR:   begin underflow = (depth_q < 7'd2); cmd_sop = SOP_REPL; cmd_w = b | a; end
      OP_POP:  begin underflow = (depth_q < 7'd1); cmd_sop = SOP_POP;  end
      OP_POP2: begin underflow = (depth_q < 7'd2); cmd_sop = SOP_POP2; end
      OP_SWAP: begin underflow = (depth_q < 7'd2); cmd_sop = SOP_SWAP; end
      OP_DUP:  begin underflow = (depth_q < 7'd1); cmd_sop = SOP_PUSH; cmd_w = a; end
      default: illegal = 1'b1;
    endcase
  end

  // Sequencer next state: accept, one-cycle issue strobe, settle while the stack updates, respond.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sop_d   = SOP_HOLD;
    w_d     = '0;
    top_d   = top_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    depth_d = depth_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          err_d = illegal | underflow;
          if (illegal || underflow || (cmd_op == OP_NOP)) begin
            // Stack is untouched, so the current top is already the post-command top.
            top_d   = a;
            state_d = S_RESP;
          end else begin
            sop_d   = cmd_sop;
            w_d     = cmd_w;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // register_stack captures on this edge; depth tracks it in lockstep.
        case (op_q)
          OP_PUSH, OP_DUP: begin
            if (depth_q == DEPTH_C) ovf_d = 1'b1;
            else                    depth_d = depth_q + 7'd1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_POP: depth_d = depth_q - 7'd1;
          OP_POP2: depth_d = depth_q - 7'd2;
          default: depth_d = depth_q;
        endcase
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        top_d   = a;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight command silently.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      sop_q   <= SOP_HOLD;
      w_q     <= '0;
      top_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sop_q   <= sop_d;
      w_q     <= w_d;
      top_q   <= top_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      depth_q <= depth_d;
    end
  end

  // Ready is masked by reset so the decode stage never sees a ready while the block is held.
  assign cmd_ready = (state_q == S_IDLE) & RST_N;
  assign stackOP   = sop_q;
  assign w         = w_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = (state_q == S_RESP) & err_q;
  assign rsp_top   = top_q;
  assign depth     = depth_q;
  assign overflow  = ovf_q;

endmodule
